// File: rtl/fifo_wr_master_if.sv
// Upstream stream and FIFO write-port signals of fifo_wr_master.
// The master modport is the block's view; the slave modport is the environment's.
interface fifo_wr_master_if #(
  parameter int DATA_WIDTH = 18
);
  logic                  s_valid_i;
  logic [DATA_WIDTH-1:0] s_data_i;
  logic                  s_ready_o;

  logic                  fifo_rst_n_o;
  logic                  fifo_daf_o;
  logic                  fifo_wr_o;
  logic [DATA_WIDTH-1:0] fifo_data_o;
  logic                  fifo_wr_ok_i;
  logic                  fifo_half_full_i;
  logic                  fifo_af_ae_i;

  modport master (
    input  s_valid_i, s_data_i, fifo_wr_ok_i, fifo_half_full_i, fifo_af_ae_i,
    output s_ready_o, fifo_rst_n_o, fifo_daf_o, fifo_wr_o, fifo_data_o
  );

  modport slave (
    output s_valid_i, s_data_i, fifo_wr_ok_i, fifo_half_full_i, fifo_af_ae_i,
    input  s_ready_o, fifo_rst_n_o, fifo_daf_o, fifo_wr_o, fifo_data_o
  );
endinterface

// File: rtl/fifo_wr_master.sv
// Programs the almost-full offset of an attached FIFO after reset, then streams
// upstream words into it through a 2-entry skid buffer.
module fifo_wr_master #(
  parameter int DATA_WIDTH   = 18,
  parameter int FIFO_ENTRIES = 1024,
  parameter int AF_OFFSET    = 0
) (
  input  logic                    clk_wr_i,
  input  logic                    rst_n_i,
  fifo_wr_master_if.master        bus,
  output logic                    cfg_done_o,
  output logic                    near_full_o,
  output logic [15:0]             wr_count_o
);

  typedef enum logic [2:0] {
    SETUP,
    STROBE,
    RELEASE,
    SETTLE,
    RUN
  } state_e;

  localparam logic [DATA_WIDTH-1:0] OFFSET_WORD   = DATA_WIDTH'(AF_OFFSET);
  localparam bit                    CUSTOM_OFFSET = (AF_OFFSET != 0);

  if ((FIFO_ENTRIES < 4) || ((FIFO_ENTRIES & (FIFO_ENTRIES - 1)) != 0) ||
      (AF_OFFSET < 0) || (AF_OFFSET > FIFO_ENTRIES / 2 - 1)) begin : g_bad_cfg
    $error("fifo_wr_master: FIFO_ENTRIES/AF_OFFSET combination is not supported");
  end

  // ---------------------------------------------------------------------------
  // Programming FSM
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   hold_q,  hold_d;       // set during the second cycle of STROBE/SETTLE
  logic   fifo_rst_n_q, fifo_rst_n_d;
  logic   fifo_daf_q,   fifo_daf_d;
  logic   cfg_done_q,   cfg_done_d;

  // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk_wr_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= SETUP;
      hold_q       <= 1'b0;
      fifo_rst_n_q <= 1'b0;
      fifo_daf_q   <= 1'b1;
      cfg_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      fifo_rst_n_q <= fifo_rst_n_d;
      fifo_daf_q   <= fifo_daf_d;
      cfg_done_q   <= cfg_done_d;
    end
  end

  // Outputs are decoded from the next state so the output flops line up with
  // the state register cycle for cycle.
  // NOTE: every signal gets a default before the case, so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    hold_d       = 1'b0;
    fifo_rst_n_d = 1'b1;
    fifo_daf_d   = 1'b1;
    cfg_done_d   = 1'b0;

    unique case (state_q)
      SETUP:   state_d = CUSTOM_OFFSET ? STROBE : RELEASE;
      STROBE:  if (hold_q) state_d = RELEASE; else hold_d = 1'b1;
      RELEASE: state_d = SETTLE;
      SETTLE:  if (hold_q) state_d = RUN; else hold_d = 1'b1;
      RUN:     state_d = RUN;
      default: state_d = SETUP;
    endcase

    case (state_d)
      SETUP:   fifo_rst_n_d = 1'b0;
      STROBE: begin
        fifo_rst_n_d = 1'b0;
        fifo_daf_d   = 1'b0;
      end
      RELEASE: fifo_daf_d = !CUSTOM_OFFSET;
      RUN:     cfg_done_d = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Skid buffer: head drives the FIFO port directly, tail catches one extra word
  // ---------------------------------------------------------------------------
  logic                  run;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic                  head_vld_q;
  logic                  tail_vld_q;
  logic [15:0]           wr_count_q;

  assign run           = (state_q == RUN);
  assign bus.s_ready_o = run & ~tail_vld_q;
  assign push          = bus.s_valid_i & bus.s_ready_o;
  assign pop           = head_vld_q & bus.fifo_wr_ok_i;

  // Outside RUN the head register carries the offset word on the data bus.
  always_ff @(posedge clk_wr_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q     <= '0;
      head_vld_q <= 1'b0;
      tail_vld_q <= 1'b0;
      wr_count_q <= '0;
    end else if (!run) begin
      head_q <= OFFSET_WORD;
    end else if (pop) begin
      wr_count_q <= wr_count_q + 16'd1;
      if (tail_vld_q) begin
        head_q     <= tail_q;
        tail_vld_q <= 1'b0;
      end else if (push) begin
        head_q <= bus.s_data_i;
      end else begin
        head_vld_q <= 1'b0;
      end
    end else if (push) begin
      if (head_vld_q) begin
        tail_vld_q <= 1'b1;
      end else begin
        head_q     <= bus.s_data_i;
        head_vld_q <= 1'b1;
      end
    end
  end

  // NOTE: the tail slot is storage without reset; it is only read while tail_vld_q is set.
  always_ff @(posedge clk_wr_i) begin
    if (push && head_vld_q && !pop) begin
      tail_q <= bus.s_data_i;
    end
  end

  assign bus.fifo_rst_n_o = fifo_rst_n_q;
  assign bus.fifo_daf_o   = fifo_daf_q;
  assign bus.fifo_wr_o    = head_vld_q;
  assign bus.fifo_data_o  = head_q;
  assign cfg_done_o       = cfg_done_q;
  assign wr_count_o       = wr_count_q;

  // Status only: the FIFO's own wr_ok provides the back-pressure.
  assign near_full_o = bus.fifo_af_ae_i & bus.fifo_half_full_i;

endmodule

// File: tb/tb_fifo_wr_master.sv
// Directed bench for fifo_wr_master: one instance with a custom offset (100)
// for programming and streaming, one with the default offset (0).
module tb_fifo_wr_master;

  localparam int DW = 18;

  logic        clk;
  logic        rst_n;
  logic        cfg_done_a, near_full_a, cfg_done_b, near_full_b;
  logic [15:0] wr_count_a, wr_count_b;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] log_q[$];
  bit            log_en = 1'b0;

  fifo_wr_master_if #(.DATA_WIDTH(DW)) ia ();
  fifo_wr_master_if #(.DATA_WIDTH(DW)) ib ();

  fifo_wr_master #(.DATA_WIDTH(DW), .FIFO_ENTRIES(1024), .AF_OFFSET(100)) dut_a (
    .clk_wr_i    (clk),
    .rst_n_i     (rst_n),
    .bus         (ia),
    .cfg_done_o  (cfg_done_a),
    .near_full_o (near_full_a),
    .wr_count_o  (wr_count_a)
  );

  fifo_wr_master #(.DATA_WIDTH(DW), .FIFO_ENTRIES(1024), .AF_OFFSET(0)) dut_b (
    .clk_wr_i    (clk),
    .rst_n_i     (rst_n),
    .bus         (ib),
    .cfg_done_o  (cfg_done_b),
    .near_full_o (near_full_b),
    .wr_count_o  (wr_count_b)
  );

  always #5 clk = ~clk;

  // Records every write the FIFO would accept on the following rising edge.
  always @(negedge clk) begin
    if (log_en && ia.fifo_wr_o && ia.fifo_wr_ok_i) log_q.push_back(ia.fifo_data_o);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int idx);
    if (idx < log_q.size()) return 32'(log_q[idx]);
    return 'x;
  endfunction

  task automatic check_reset_a(input string tag);
    check({tag, " fifo_rst_n"}, ia.fifo_rst_n_o, 0);
    check({tag, " daf"},        ia.fifo_daf_o,   1);
    check({tag, " wr"},         ia.fifo_wr_o,    0);
    check({tag, " data"},       ia.fifo_data_o,  0);
    check({tag, " ready"},      ia.s_ready_o,    0);
    check({tag, " cfg_done"},   cfg_done_a,      0);
    check({tag, " wr_count"},   wr_count_a,      0);
    check({tag, " cfg_done_b"}, cfg_done_b,      0);
  endtask

  // Called one time unit after a rising edge with rst_n low; releases reset
  // and follows both programming sequences cycle by cycle.
  task automatic run_config(input string tag);
    bit exp_daf_a [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bit exp_rst_a [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      check($sformatf("%s c%0d daf_a", tag, k + 1),  ia.fifo_daf_o,   exp_daf_a[k]);
      check($sformatf("%s c%0d rst_a", tag, k + 1),  ia.fifo_rst_n_o, exp_rst_a[k]);
      check($sformatf("%s c%0d done_a", tag, k + 1), cfg_done_a,      0);
      check($sformatf("%s c%0d wr_a", tag, k + 1),   ia.fifo_wr_o,    0);
      check($sformatf("%s c%0d daf_b", tag, k + 1),  ib.fifo_daf_o,   1);
      check($sformatf("%s c%0d rst_b", tag, k + 1),  ib.fifo_rst_n_o, (k >= 1));
      check($sformatf("%s c%0d done_b", tag, k + 1), cfg_done_b,      (k >= 4));
      if (k == 0) check({tag, " setup data_a"},   ia.fifo_data_o, 0);
      if (k == 3) check({tag, " release data_a"}, ia.fifo_data_o, 100);
    end
    tick();
    check({tag, " run done_a"},  cfg_done_a,     1);
    check({tag, " run ready_a"}, ia.s_ready_o,   1);
    check({tag, " run data_a"},  ia.fifo_data_o, 100);
    check({tag, " run wr_a"},    ia.fifo_wr_o,   0);
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b1;
    ia.s_valid_i = 1'b0; ia.s_data_i = '0; ia.fifo_wr_ok_i = 1'b0;
    ia.fifo_half_full_i = 1'b0; ia.fifo_af_ae_i = 1'b0;
    ib.s_valid_i = 1'b0; ib.s_data_i = '0; ib.fifo_wr_ok_i = 1'b1;
    ib.fifo_half_full_i = 1'b0; ib.fifo_af_ae_i = 1'b0;

    #3 rst_n = 1'b0;
    tick();
    tick();
    check_reset_a("reset");

    run_config("cfg1");

    // Back-to-back stream of 1..8 with the FIFO always accepting.
    ia.fifo_wr_ok_i = 1'b1;
    log_q.delete();
    log_en = 1'b1;
    ia.s_valid_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      ia.s_data_i = DW'(i);
      tick();
      check($sformatf("stream%0d ready", i), ia.s_ready_o,   1);
      check($sformatf("stream%0d wr", i),    ia.fifo_wr_o,   1);
      check($sformatf("stream%0d data", i),  ia.fifo_data_o, i);
      check($sformatf("stream%0d count", i), wr_count_a,     i - 1);
    end
    ia.s_valid_i = 1'b0;
    tick();
    check("stream idle wr",   ia.fifo_wr_o,   0);
    check("stream idle data", ia.fifo_data_o, 8);
    check("stream count",     wr_count_a,     8);
    check("stream log size",  log_q.size(),   8);
    for (int j = 0; j < 8; j++) check($sformatf("stream order%0d", j), log_at(j), j + 1);

    // near_full is a plain AND of the two flags and never blocks the input.
    for (int m = 0; m < 4; m++) begin
      ia.fifo_half_full_i = m[0];
      ia.fifo_af_ae_i     = m[1];
      #1;
      check($sformatf("near_full hf=%0d af=%0d", m[0], m[1]), near_full_a, (m == 3));
      check($sformatf("near_full ready m=%0d", m), ia.s_ready_o, 1);
    end
    ia.fifo_half_full_i = 1'b0;
    ia.fifo_af_ae_i     = 1'b0;

    // Five cycles of back-pressure in the middle of a stream.
    log_q.delete();
    ia.s_valid_i = 1'b1;
    ia.s_data_i  = DW'(9);
    tick();
    check("stall a data",  ia.fifo_data_o, 9);
    check("stall a ready", ia.s_ready_o,   1);
    ia.fifo_wr_ok_i = 1'b0;
    ia.s_data_i     = DW'(10);
    tick();
    check("stall b data",  ia.fifo_data_o, 9);
    check("stall b ready", ia.s_ready_o,   0);
    ia.s_data_i = DW'(11);
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("stall hold%0d data", c),  ia.fifo_data_o, 9);
      check($sformatf("stall hold%0d wr", c),    ia.fifo_wr_o,   1);
      check($sformatf("stall hold%0d ready", c), ia.s_ready_o,   0);
      check($sformatf("stall hold%0d count", c), wr_count_a,     8);
    end
    ia.fifo_wr_ok_i = 1'b1;
    tick();
    check("stall g data",  ia.fifo_data_o, 10);
    check("stall g ready", ia.s_ready_o,   1);
    check("stall g count", wr_count_a,     9);
    tick();
    check("stall h data",  ia.fifo_data_o, 11);
    check("stall h count", wr_count_a,     10);
    ia.s_data_i = DW'(12);
    tick();
    check("stall i data",  ia.fifo_data_o, 12);
    check("stall i count", wr_count_a,     11);
    ia.s_valid_i = 1'b0;
    tick();
    check("stall j wr",    ia.fifo_wr_o, 0);
    check("stall j count", wr_count_a,   12);
    check("stall log size", log_q.size(), 4);
    for (int j = 0; j < 4; j++) check($sformatf("stall order%0d", j), log_at(j), j + 9);

    // Reset with two words held in the buffer.
    log_q.delete();
    ia.fifo_wr_ok_i = 1'b0;
    ia.s_valid_i    = 1'b1;
    ia.s_data_i     = DW'('h20);
    tick();
    ia.s_data_i = DW'('h21);
    tick();
    ia.s_valid_i = 1'b0;
    check("full ready", ia.s_ready_o,   0);
    check("full wr",    ia.fifo_wr_o,   1);
    check("full data",  ia.fifo_data_o, 'h20);
    #2 rst_n = 1'b0;
    #1;
    check_reset_a("midreset");
    ia.fifo_wr_ok_i = 1'b1;
    tick();
    tick();
    run_config("cfg2");
    repeat (4) tick();
    check("discard wr",       ia.fifo_wr_o, 0);
    check("discard count",    wr_count_a,   0);
    check("discard log size", log_q.size(), 0);

    // 65537 accepted writes: the count passes 0xFFFF, wraps to 0, lands on 1.
    log_en       = 1'b0;
    ia.s_valid_i = 1'b1;
    for (int i = 1; i <= 65537; i++) begin
      ia.s_data_i = DW'(i);
      tick();
      if (i == 65536) check("wrap count ffff", wr_count_a, 16'hFFFF);
    end
    check("wrap count zero", wr_count_a,     0);
    check("wrap last data",  ia.fifo_data_o, 65537);
    ia.s_valid_i = 1'b0;
    tick();
    check("wrap count one", wr_count_a,   1);
    check("wrap idle wr",   ia.fifo_wr_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
